// File: rtl/sram_multiport_arbiter.sv
// Multi-channel arbiter in front of a single asynchronous 16-bit SRAM (IDLE/ACCESS/RECOVER).
// Round-robin by default; define SRAM_ARB_FIXED_PRIO_EN for fixed priority (channel 0 highest).
module sram_multiport_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH-1:0]    ch_we,
  output logic [NUM_CH-1:0]    ch_gnt,
  output logic [NUM_CH-1:0]    ch_rvalid,
  input  logic [NUM_CH*20-1:0] ch_addr,
  input  logic [NUM_CH*16-1:0] ch_wdata,
  input  logic [NUM_CH*2-1:0]  ch_be,
  output logic [15:0]          ch_rdata,
  output logic [19:0]          sram_addr,
  output logic [15:0]          sram_dq_o,
  output logic                 sram_dq_oe,
  input  logic [15:0]          sram_dq_i,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_lb_n,
  output logic                 sram_ub_n
);

  localparam int          IW          = 2;
  localparam logic [2:0]  LP_WAIT_LAST = 3'(WAIT_CYC);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic [NUM_CH-1:0]   r_win_oh;
  logic                r_we;
  logic [19:0]         r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_rdata;
  logic [NUM_CH-1:0]   r_gnt;
  logic [NUM_CH-1:0]   r_rvalid;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic                r_lb_n;
  logic                r_ub_n;
  logic                r_dq_oe;

  logic                w_any;
  logic [IW-1:0]       w_win;
  logic [NUM_CH-1:0]   w_win_oh;
  logic [19:0]         w_addr;
  logic [15:0]         w_wdata;
  logic                w_we;
  logic [1:0]          w_be;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Scanning downwards leaves the lowest requesting index as the winner.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_req[i]) begin
        w_any = 1'b1;
        w_win = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] r_rr_ptr;

  function automatic int rr_slot(input logic [IW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NUM_CH) s = s - NUM_CH;
    return s;
  endfunction

  // r_rr_ptr is the first channel searched; the closest requester after it wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_req[i] && (rr_slot(r_rr_ptr, k) == i)) begin
          w_any = 1'b1;
          w_win = IW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_rr_ptr <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_rr_ptr <= (int'(w_win) == NUM_CH - 1) ? '0 : w_win + IW'(1);
    end
  end
`endif

  always_comb begin
    w_win_oh = '0;
    w_addr   = '0;
    w_wdata  = '0;
    w_we     = 1'b0;
    w_be     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_win == IW'(i)) begin
        w_win_oh[i] = 1'b1;
        w_addr      = ch_addr[i*20 +: 20];
        w_wdata     = ch_wdata[i*16 +: 16];
        w_we        = ch_we[i];
        w_be        = ch_be[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_win_oh <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      case (r_state)
        // IDLE: arbitrate and launch the strobes for the first ACCESS cycle
        IDLE: begin
          if (w_any) begin
            r_state  <= ACCESS;
            r_cnt    <= '0;
            r_win_oh <= w_win_oh;
            r_we     <= w_we;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_gnt    <= w_win_oh;
            r_ce_n   <= 1'b0;
            r_we_n   <= ~w_we;
            r_oe_n   <= w_we;
            r_dq_oe  <= w_we;
            r_lb_n   <= ~w_be[0];
            r_ub_n   <= ~w_be[1];
          end
        end
        // ACCESS: WAIT_CYC+1 cycles; read data is captured on the closing edge
        ACCESS: begin
          if (r_cnt == LP_WAIT_LAST) begin
            r_state <= RECOVER;
            r_cnt   <= '0;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            r_ub_n  <= 1'b1;
            if (!r_we) begin
              r_rdata  <= sram_dq_i;
              r_rvalid <= r_win_oh;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        // RECOVER: strobes released while write data keeps driving for hold time
        RECOVER: begin
          r_state <= IDLE;
          r_dq_oe <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ch_gnt     = r_gnt;
  assign ch_rvalid  = r_rvalid;
  assign ch_rdata   = r_rdata;
  assign sram_addr  = r_addr;
  assign sram_dq_o  = r_wdata;
  assign sram_dq_oe = r_dq_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_lb_n  = r_lb_n;
  assign sram_ub_n  = r_ub_n;

endmodule
